fpu_out_result_queue: RTL and testbench

//   Elastic result buffer between the FPU datapath and the FPU_out bus.
//   It captures each completed result together with its IEEE exception flags,

---
 rtl/fpu_out_result_queue.sv | 112 +++++++++++
 tb/tb_fpu_out_result_queue.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fpu_out_result_queue.sv
// Purpose: elastic in-order result buffer between the FPU datapath and the FPU_out bus, with sticky IEEE flags and a delivered-result count.
// Latency: an entry pushed on edge N is presented on out_* after that edge (cycle N+1); there is no in->out bypass.
// Backpressure: in_ready is derived from the registered level only, so a pop while full frees a slot one cycle later.
//
// Ports:
//   clock, reset                 rising-edge clock; asynchronous active-high reset
//   in_valid/in_ready            datapath push handshake; in_result/in_flags are the payload
//   out_valid/out_ready          FPU_out pop handshake; out_result/out_flags are the head entry (zero when empty)
//   flush                        synchronous discard of every queued entry; wins over push/pop
//   flags_clr                    clears sticky_flags (a pop in the same cycle is still recorded)
//   sticky_flags                 OR of the flags of every delivered result
//   result_count                 number of delivered results, saturating
//   level                        current occupancy, 0..DEPTH
module fpu_out_result_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int FLAG_WIDTH = 5,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_result,
    input  logic [FLAG_WIDTH-1:0]     in_flags,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_result,
    output logic [FLAG_WIDTH-1:0]     out_flags,
    input  logic                      flush,
    input  logic                      flags_clr,
    output logic [FLAG_WIDTH-1:0]     sticky_flags,
    output logic [CNT_WIDTH-1:0]      result_count,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic [FLAG_WIDTH-1:0] flags;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    assign in_ready  = (level != LW'(DEPTH));
    assign out_valid = (level != '0);

    // Handshakes in a flush cycle are swallowed: nothing is stored, delivered or counted.
    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // Head comes straight from registered storage; gated so stale slots never leak out while empty.
    assign head       = mem[rd_ptr];
    assign out_result = out_valid ? head.result : '0;
    assign out_flags  = out_valid ? head.flags  : '0;

    // Storage needs no reset: every slot is written before level can expose it.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= '{result: in_result, flags: in_flags};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            // Leave wr_ptr where it is and drop everything between the pointers.
            rd_ptr <= wr_ptr;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sticky_flags <= '0;
            result_count <= '0;
        end else begin
            sticky_flags <= (flags_clr ? '0 : sticky_flags) | (pop ? out_flags : '0);
            if (pop && (result_count != '1)) begin
                result_count <= result_count + CNT_WIDTH'(1);
            end
        end
    end

    a_no_push_when_full : assert property (
        @(posedge clock) disable iff (reset)
        !(in_valid && in_ready && (level == LW'(DEPTH)))
    );

endmodule

// File: tb/tb_fpu_out_result_queue.sv
// Purpose: randomized and directed self-checking bench for fpu_out_result_queue against a queue-based reference model.
// Latency: outputs are compared on the falling edge, one cycle after the stimulus that caused them.
// Backpressure: the model decides acceptance from its own occupancy; the bench never reads the DUT to decide.
module tb_fpu_out_result_queue;

    localparam int DW   = 32;
    localparam int FW   = 5;
    localparam int DEP  = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clock;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_result;
    logic [FW-1:0]   in_flags;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_result;
    logic [FW-1:0]   out_flags;
    logic            flush;
    logic            flags_clr;
    logic [FW-1:0]   sticky_flags;
    logic [CW-1:0]   result_count;
    logic [2:0]      level;

    fpu_out_result_queue #(
        .DATA_WIDTH (DW),
        .FLAG_WIDTH (FW),
        .DEPTH      (DEP),
        .CNT_WIDTH  (CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .flush        (flush),
        .flags_clr    (flags_clr),
        .sticky_flags (sticky_flags),
        .result_count (result_count),
        .level        (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] r;
        logic [FW-1:0] f;
    } ent_t;

    ent_t          q[$];
    logic [FW-1:0] m_sticky;
    int            m_count;
    int            n_checks;
    int            n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int sz;
        sz = q.size();
        check("in_ready",  32'(in_ready),  32'(sz != DEP));
        check("out_valid", 32'(out_valid), 32'(sz != 0));
        check("out_result", out_result, (sz != 0) ? q[0].r : 32'h0);
        check("out_flags", 32'(out_flags), (sz != 0) ? 32'(q[0].f) : 32'h0);
        check("level",     32'(level),     32'(sz));
        check("sticky",    32'(sticky_flags), 32'(m_sticky));
        check("count",     32'(result_count), 32'(m_count));
    endtask

    task automatic model_reset();
        q.delete();
        m_sticky = '0;
        m_count  = 0;
    endtask

    // One clock cycle: compare, drive, update the model at the edge, return at the next falling edge.
    task automatic step(input logic iv, input logic [DW-1:0] res, input logic [FW-1:0] fl,
                        input logic ordy, input logic fls, input logic clr);
        logic do_push;
        logic do_pop;
        ent_t e;
        check_outputs();
        in_valid  = iv;
        in_result = res;
        in_flags  = fl;
        out_ready = ordy;
        flush     = fls;
        flags_clr = clr;
        do_push = iv && (q.size() < DEP);
        do_pop  = ordy && (q.size() != 0);
        @(posedge clock);
        if (clr) m_sticky = '0;
        if (fls) begin
            q.delete();
        end else begin
            if (do_pop) begin
                m_sticky = m_sticky | q[0].f;
                if (m_count < CMAX) m_count++;
                void'(q.pop_front());
            end
            if (do_push) begin
                e.r = res;
                e.f = fl;
                q.push_back(e);
            end
        end
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        in_valid  = 1'b0;
        in_result = '0;
        in_flags  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        flags_clr = 1'b0;
        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Single result with out_ready held high; delivered the following cycle.
        step(1'b1, 32'h3F80_0000, 5'b00001, 1'b1, 1'b0, 1'b0);
        check("t1_out_result", out_result, 32'h3F80_0000);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("t1_sticky", 32'(sticky_flags), 32'h1);
        check("t1_count", 32'(result_count), 32'h1);

        // Stalled consumer: A..D fill the queue, E is held off until space frees up.
        for (int i = 0; i < 5; i++) step(1'b1, 32'hA0 + 32'(i), 5'(i), 1'b0, 1'b0, 1'b0);
        check("t2_full_in_ready", 32'(in_ready), 32'h0);
        step(1'b1, 32'hA4, 5'd4, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hA4, 5'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("t2_drained_level", 32'(level), 32'h0);

        // Steady push+pop at level 2, enough cycles for several pointer wraps.
        for (int i = 0; i < 2; i++) step(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, $urandom, 5'($urandom_range(0, 31)), 1'b1, 1'b0, 1'b0);
        check("t3_level", 32'(level), 32'h2);
        idle(1);
        for (int i = 0; i < 2; i++) step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

        // Flush at level 3 together with a push and a pop.
        for (int i = 0; i < 3; i++) step(1'b1, 32'hC0 + 32'(i), 5'b00010, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'hDEAD_BEEF, 5'b11111, 1'b1, 1'b1, 1'b0);
        check("t4_level", 32'(level), 32'h0);
        check("t4_out_valid", 32'(out_valid), 32'h0);
        idle(2);

        // Clear in the same cycle as a pop: the popped flags survive.
        step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h1111, 5'b00100, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h2222, 5'b10000, 1'b1, 1'b0, 1'b0);
        check("t5_sticky_before", 32'(sticky_flags), 32'h04);
        step(1'b0, '0, '0, 1'b1, 1'b1 & 1'b0, 1'b1);
        check("t5_sticky_after", 32'(sticky_flags), 32'h10);

        // Asynchronous reset mid-stream at level 3.
        for (int i = 0; i < 3; i++) step(1'b1, 32'hE0 + 32'(i), 5'b01000, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(negedge clock);
        reset = 1'b0;
        step(1'b1, 32'hF00D, 5'b00011, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        idle(1);

        // Random traffic, including saturation of the narrow counter.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 9) < 7), $urandom, 5'($urandom_range(0, 31)),
                 ($urandom_range(0, 9) < 6), ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 15) == 0));
        end
        check("rand_count_saturated", 32'(result_count), 32'(CMAX));
        check_outputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
